// File: rtl/display_digit_counter.sv
// -----------------------------------------------------------------------------
// display_digit_counter
//
// One decimal/hex digit for a seven-segment display.
//  - Counts 0..MAX_NUMBER. Each 0->1 transition on incrementIn advances the
//    count by one, so a level held high gives only one step.
//  - Wrapping from MAX_NUMBER to 0 produces a registered one-cycle pulse on
//    overflowOut. That pulse can drive incrementIn of the next digit on the
//    same clock to build a multi-digit counter.
//  - The segment decode is combinational from the count register.
//
// Ports
//   clkIn            in   system clock, rising edge
//   resetIn          in   asynchronous active-low reset
//   incrementIn      in   count request (edge detected internally)
//   dotIn            in   decimal point request, drives segment dp directly
//   overflowOut      out  one-cycle pulse in the cycle after a wrap
//   segmentEnableOut out  active-high segments {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module display_digit_counter #(
  parameter int MAX_NUMBER = 9
) (
  input  logic       clkIn,
  input  logic       resetIn,
  input  logic       incrementIn,
  input  logic       dotIn,
  output logic       overflowOut,
  output logic [7:0] segmentEnableOut
);

  // A count range that does not fit the 4-bit digit is a build error.
  generate
    if (MAX_NUMBER < 1 || MAX_NUMBER > 15) begin : g_bad_max_number
      $error("display_digit_counter: MAX_NUMBER must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] MaxCount = 4'(MAX_NUMBER);

  logic [3:0] count_q, count_d;
  logic       inc_prev_q, inc_prev_d;
  logic       overflow_q, overflow_d;
  logic       inc_rise;
  logic [6:0] seg_abcdefg;

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      count_q    <= 4'd0;
      inc_prev_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      inc_prev_q <= inc_prev_d;
      overflow_q <= overflow_d;
    end
  end

  // inc_prev_q resets to 0, so an incrementIn already high at the first edge
  // after reset counts as a rising edge.
  always_comb begin
    inc_prev_d = incrementIn;
    inc_rise   = incrementIn & ~inc_prev_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    if (inc_rise) begin
      if (count_q == MaxCount) begin
        count_d    = 4'd0;
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  // Segment order within seg_abcdefg is {g,f,e,d,c,b,a}.
  always_comb begin
    seg_abcdefg = 7'h3F;
    case (count_q)
      4'h0: seg_abcdefg = 7'h3F;
      4'h1: seg_abcdefg = 7'h06;
      4'h2: seg_abcdefg = 7'h5B;
      4'h3: seg_abcdefg = 7'h4F;
      4'h4: seg_abcdefg = 7'h66;
      4'h5: seg_abcdefg = 7'h6D;
      4'h6: seg_abcdefg = 7'h7D;
      4'h7: seg_abcdefg = 7'h07;
      4'h8: seg_abcdefg = 7'h7F;
      4'h9: seg_abcdefg = 7'h6F;
      4'hA: seg_abcdefg = 7'h77;
      4'hB: seg_abcdefg = 7'h7C;
      4'hC: seg_abcdefg = 7'h39;
      4'hD: seg_abcdefg = 7'h5E;
      4'hE: seg_abcdefg = 7'h79;
      4'hF: seg_abcdefg = 7'h71;
      default: seg_abcdefg = 7'h3F;
    endcase
  end

  assign segmentEnableOut = {dotIn, seg_abcdefg};
  assign overflowOut      = overflow_q;

endmodule

// File: tb/tb_display_digit_counter.sv
// -----------------------------------------------------------------------------
// Bench for display_digit_counter. Five instances share clock and reset:
//   0: MAX 9   on inc_a / dot_a
//   1: MAX 5   on inc_b
//   2: MAX 15  on inc_b
//   3: MAX 9   on inc_c  (lower digit of a chain)
//   4: MAX 5   on the overflow of instance 3 (upper digit)
// The reference model counts rising edges of each input and derives the
// digit as (edges mod (MAX+1)); a wrap is every (MAX+1)-th edge.
// -----------------------------------------------------------------------------
module tb_display_digit_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc_a = 1'b0;
  logic inc_b = 1'b0;
  logic inc_c = 1'b0;
  logic dot_a = 1'b0;

  logic [7:0] seg_o [5];
  logic       ovf_o [5];

  always #5 clk = ~clk;

  display_digit_counter #(.MAX_NUMBER(9)) u_d9 (
    .clkIn(clk), .resetIn(rst_n), .incrementIn(inc_a), .dotIn(dot_a),
    .overflowOut(ovf_o[0]), .segmentEnableOut(seg_o[0]));
  display_digit_counter #(.MAX_NUMBER(5)) u_d5 (
    .clkIn(clk), .resetIn(rst_n), .incrementIn(inc_b), .dotIn(1'b0),
    .overflowOut(ovf_o[1]), .segmentEnableOut(seg_o[1]));
  display_digit_counter #(.MAX_NUMBER(15)) u_d15 (
    .clkIn(clk), .resetIn(rst_n), .incrementIn(inc_b), .dotIn(1'b0),
    .overflowOut(ovf_o[2]), .segmentEnableOut(seg_o[2]));
  display_digit_counter #(.MAX_NUMBER(9)) u_lo (
    .clkIn(clk), .resetIn(rst_n), .incrementIn(inc_c), .dotIn(1'b0),
    .overflowOut(ovf_o[3]), .segmentEnableOut(seg_o[3]));
  display_digit_counter #(.MAX_NUMBER(5)) u_hi (
    .clkIn(clk), .resetIn(rst_n), .incrementIn(ovf_o[3]), .dotIn(1'b0),
    .overflowOut(ovf_o[4]), .segmentEnableOut(seg_o[4]));

  // ---------------- reference model ----------------
  logic [6:0] tbl [16];
  int         maxn [5];
  int         ev [5];
  bit         prev [5];
  bit         ovf_exp [5];

  int n_total = 0;
  int n_pass  = 0;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      ev[i] = 0; prev[i] = 1'b0; ovf_exp[i] = 1'b0;
    end
  endtask

  // Called at each rising edge with the inputs the DUT samples there.
  // The upper chained digit sees the lower digit's pulse from the cycle before.
  task automatic model_update();
    bit in_v [5];
    in_v[0] = inc_a; in_v[1] = inc_b; in_v[2] = inc_b;
    in_v[3] = inc_c; in_v[4] = ovf_exp[3];
    for (int i = 0; i < 5; i++) begin
      ovf_exp[i] = 1'b0;
      if (in_v[i] && !prev[i]) begin
        ev[i]++;
        if (ev[i] % (maxn[i] + 1) == 0) ovf_exp[i] = 1'b1;
      end
      prev[i] = in_v[i];
    end
  endtask

  function automatic int exp_cnt(int i);
    return ev[i] % (maxn[i] + 1);
  endfunction

  function automatic logic [7:0] exp_seg(int i);
    logic d;
    d = (i == 0) ? dot_a : 1'b0;
    return {d, tbl[exp_cnt(i)]};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(string ph);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_seg%0d", ph, i), seg_o[i], exp_seg(i));
      chk($sformatf("%s_ovf%0d", ph, i), {7'd0, ovf_o[i]}, {7'd0, ovf_exp[i]});
    end
  endtask

  task automatic tick(string ph);
    @(posedge clk);
    model_update();
    #2;
    check_all(ph);
  endtask

  task automatic pulse_a(string ph);
    inc_a = 1'b1; tick(ph);
    inc_a = 1'b0; tick(ph);
  endtask

  int hi_pulses;

  initial begin
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    maxn = '{9, 5, 15, 9, 5};
    model_reset();

    // Reset state, independent of the clock, with dp following dotIn.
    #3;
    chk("reset_seg_dot0", seg_o[0], 8'h3F);
    chk("reset_ovf", {7'd0, ovf_o[0]}, 8'h00);
    dot_a = 1'b1; #1;
    chk("reset_seg_dot1", seg_o[0], 8'hBF);
    dot_a = 1'b0;
    @(posedge clk); #2;
    check_all("reset_clk");
    rst_n = 1'b1;

    // Ten single pulses on the MAX 9 digit: full cycle and one wrap.
    for (int k = 0; k < 10; k++) pulse_a("ten_pulses");
    chk("ten_pulses_final", seg_o[0], 8'h3F);

    // Level held high: one step only.
    inc_a = 1'b1;
    for (int k = 0; k < 20; k++) tick("held_high");
    chk("held_high_final", seg_o[0], 8'h06);
    inc_a = 1'b0; tick("held_release");

    // MAX 5 and MAX 15 on the same 15 pulses.
    for (int k = 0; k < 15; k++) begin
      inc_b = 1'b1; tick("max5_15");
      inc_b = 1'b0; tick("max5_15");
    end
    chk("max15_shows_f", seg_o[2], 8'h71);

    // Bring digit to 3 and toggle the decimal point between edges.
    for (int k = 0; k < 20 && exp_cnt(0) != 3; k++) pulse_a("to_three");
    for (int k = 0; k < 4; k++) begin
      dot_a = ~dot_a; #1;
      chk("dot_toggle", seg_o[0], dot_a ? 8'hCF : 8'h4F);
    end
    dot_a = 1'b0;

    // Chain: 60 lower pulses give one upper wrap.
    hi_pulses = 0;
    for (int k = 0; k < 60; k++) begin
      inc_c = 1'b1; tick("chain");
      if (ovf_o[4]) hi_pulses++;
      inc_c = 1'b0; tick("chain");
      if (ovf_o[4]) hi_pulses++;
    end
    for (int k = 0; k < 3; k++) begin
      tick("chain_tail");
      if (ovf_o[4]) hi_pulses++;
    end
    chk("chain_upper_digit", seg_o[4], 8'h3F);
    chk("chain_upper_pulses", 8'(hi_pulses), 8'd1);

    // Random traffic on all inputs.
    for (int k = 0; k < 300; k++) begin
      inc_a = 1'($urandom_range(0, 1));
      inc_b = 1'($urandom_range(0, 1));
      inc_c = 1'($urandom_range(0, 1));
      dot_a = 1'($urandom_range(0, 1));
      tick("random");
    end
    inc_a = 1'b0; inc_b = 1'b0; inc_c = 1'b0; dot_a = 1'b0;
    tick("random_idle");

    // Reset between edges with the digit at 7.
    for (int k = 0; k < 20 && exp_cnt(0) != 7; k++) pulse_a("to_seven");
    chk("at_seven", seg_o[0], 8'h07);
    rst_n = 1'b0; model_reset(); #1;
    chk("async_reset_seg", seg_o[0], 8'h3F);
    check_all("async_reset");
    #2 rst_n = 1'b1;
    tick("after_reset");

    // Reset cancels a pending overflow pulse.
    for (int k = 0; k < 20 && exp_cnt(0) != 9; k++) pulse_a("to_nine");
    inc_a = 1'b1; tick("wrap_before_reset");
    chk("wrap_pulse_seen", {7'd0, ovf_o[0]}, 8'h01);
    rst_n = 1'b0; model_reset(); #1;
    chk("reset_cancels_ovf", {7'd0, ovf_o[0]}, 8'h00);
    check_all("reset_cancel");

    // incrementIn high across reset release counts at the first edge.
    #2 rst_n = 1'b1;
    tick("first_edge_inc");
    chk("first_edge_inc_to_1", seg_o[0], 8'h06);
    inc_a = 1'b0;
    tick("end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
